// File: rtl/serial_borrow_subtractor_pkg.sv
// Shared types for the serial borrow subtractor.
// State encoding and the default operand width.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_W = 4;

endpackage

// File: rtl/serial_borrow_subtractor_fs.sv
// One-bit full subtractor cell: d = a - b - bin.
// Purely combinational; bout is the borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // difference bit and borrow out
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial subtractor, diff = a - b, LSB first.
// Optional signed overflow output: SERIAL_SUB_SIGNED_OVF_EN.
module serial_borrow_subtractor
  import arith_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t        state;
  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic [CW-1:0] cnt;
  logic          borrow;
  logic          d;
  logic          borrow_n;
  logic          last;

  // sa doubles as the result register: d enters at the
  // top while minuend bits leave at the bottom, so the
  // minuend sign bit sits in sa[0] on the final step.
  full_subtractor u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (borrow),
    .d    (d),
    .bout (borrow_n)
  );

  assign last = (cnt == CW'(W - 1));

  // FSM, serial datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sa     <= {d, sa[W-1:1]};
          sb     <= {1'b0, sb[W-1:1]};
          borrow <= borrow_n;
          if (last) begin
            diff  <= {d, sa[W-1:1]};
            bout  <= borrow_n;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf   <= (sa[0] != sb[0]) && (d != sa[0]);
`endif
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Randomised bench for serial_borrow_subtractor, W=4.
// Reference model works on whole operands and edge times.
module tb_serial_borrow_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  serial_borrow_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: edge index, accepted edge, operands, held result
  int           e = 0;
  int           k = 0;
  bit           kvalid = 1'b0;
  int           next_free = 0;
  logic [W-1:0] pa;
  logic [W-1:0] pb;
  logic [W-1:0] mdiff = '0;
  logic         mbout = 1'b0;
  logic         movf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at edge %0d",
               name, act, exp, e);
    end
  endtask

  task automatic model_reset();
    mdiff     = '0;
    mbout     = 1'b0;
    movf      = 1'b0;
    kvalid    = 1'b0;
    next_free = 0;
  endtask

  // one clock: advance model at the edge, compare 1ns later
  task automatic cycle();
    @(posedge clk);
    e++;
    if (start && e >= next_free) begin
      k         = e;
      kvalid    = 1'b1;
      pa        = a;
      pb        = b;
      next_free = e + W + 2;
    end
    if (kvalid && e == k + W) begin
      mdiff = pa - pb;
      mbout = (pa < pb);
      movf  = (pa[W-1] != pb[W-1]) && (mdiff[W-1] != pa[W-1]);
    end
    #1;
    chk("busy", busy, kvalid && e >= k && e < k + W);
    chk("done", done, kvalid && e == k + W);
    chk("diff", diff, mdiff);
    chk("bout", bout, mbout);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    chk("ovf", ovf, movf);
`endif
  endtask

  // single directed operation with literal expectations
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ed, input logic eb);
    int nb;
    bit got;
    a     = ia;
    b     = ib;
    start = 1'b1;
    cycle();
    start = 1'b0;
    nb    = busy ? 1 : 0;
    got   = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (busy) nb++;
      if (done) got = 1'b1;
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("lit_diff", diff, ed);
    chk("lit_bout", bout, eb);
    chk("busy_cycles", nb, W);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int nd;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'b0011, 4'b0010, 4'b0001, 1'b0);
    run_op(4'b0010, 4'b0111, 4'b1011, 1'b1);
    run_op(4'b0000, 4'b0001, 4'b1111, 1'b1);
    run_op(4'b1111, 4'b1111, 4'b0000, 1'b0);
    run_op(4'b0000, 4'b1111, 4'b0001, 1'b1);
    run_op(4'b1010, 4'b1010, 4'b0000, 1'b0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    run_op(4'b0111, 4'b1000, 4'b1111, 1'b1);
    chk("lit_ovf1", ovf, 1);
    run_op(4'b0101, 4'b0011, 4'b0010, 1'b0);
    chk("lit_ovf0", ovf, 0);
`endif

    // start held high with alternating operands
    nd    = 0;
    start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a = (i % 2 == 0) ? 4'b1001 : 4'b0110;
      b = (i % 2 == 0) ? 4'b0011 : 4'b1100;
      cycle();
      if (done) nd++;
    end
    start = 1'b0;
    chk("cont_dones", nd, 4);
    repeat (8) cycle();

    // reset in the middle of RUN
    a     = 4'b0101;
    b     = 4'b0011;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_diff", diff, 0);
    chk("arst_bout", bout, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("arst_done", done, 0);
      chk("arst_busy_hold", busy, 0);
    end
    rst_n = 1'b1;
    run_op(4'b1001, 4'b0100, 4'b0101, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      start = ($urandom % 2) == 1;
      a     = W'($urandom);
      b     = W'($urandom);
      cycle();
    end
    start = 1'b0;
    repeat (8) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
